uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx byte transmitter between NUM_REQ word producers (e.g. parallel NLFSR result engines).
//  Grants round-robin. Sends each granted word as one frame: header byte, then WORD_BYTES data bytes, MSB byte first.
//  Paces bytes off uart_tx's i_Tx_Done/o_Tx_Active. Sits between the producers and a single uart_tx instance.
// PARAMETERS
//  NUM_REQ       4      number of requesters, 2..16
//  WORD_BYTES    4      data bytes per frame, 1..16
//  HDR_BASE      8'hA0  header byte = HDR_BASE | winner index; low 4 bits of HDR_BASE must be 0
//  TIMEOUT_CLKS  4096   max clocks from o_Tx_DV to i_Tx_Done before abort; must exceed 10*CLKS_PER_BIT+4
// PORTS
//  i_Clock      in   1                      system clock
//  i_Reset      in   1                      synchronous reset, active high
//  i_Req        in   NUM_REQ                level request per requester
//  i_Data       in   NUM_REQ*WORD_BYTES*8   flat words; requester k at [k*W*8 +: W*8], W=WORD_BYTES
//  o_Ack        out  NUM_REQ                one-hot 1-cycle pulse: word of that requester latched
//  o_Busy       out  1                      high from grant until frame end/abort
//  o_Err        out  1                      1-cycle pulse on timeout abort
//  o_Tx_DV      out  1                      to uart_tx i_Tx_DV, 1-cycle pulse per byte
//  o_Tx_Byte    out  8                      to uart_tx i_Tx_Byte, valid when o_Tx_DV=1
//  i_Tx_Active  in   1                      from uart_tx o_Tx_Active
//  i_Tx_Done    in   1                      from uart_tx o_Tx_Done
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; round-robin pointer r_Last=NUM_REQ-1, so requester 0 has first priority.
//  IDLE: grant only if |i_Req && !i_Tx_Active && !i_Tx_Done, which guards a uart_tx left mid-byte by reset.
//   Winner = first set i_Req[k] scanning k = r_Last+1, r_Last+2, ... mod NUM_REQ.
//   Grant cycle: latch winner's word into shift reg, latch index, set r_Last=k.
//   Same grant cycle: assert o_Ack[k] for exactly one cycle; o_Busy rises in the next cycle; go SEND.
//  SEND: o_Tx_DV=1 for one cycle. o_Tx_Byte = header on byte 0, otherwise shift reg [top byte].
//   Load the timeout counter; go WAIT_DONE.
//  WAIT_DONE: wait for i_Tx_Done=1, then go GAP.
//   Timeout counter reaches TIMEOUT_CLKS first: pulse o_Err, drop the frame, o_Busy=0, go IDLE.
//  GAP: wait for i_Tx_Done=0, i.e. uart_tx has left CLEANUP and is sampling DV.
//   Then shift reg left 8 bits and increment byte count.
//   count == WORD_BYTES+1 -> go IDLE, o_Busy=0; else go SEND.
//  DV is never issued while i_Tx_Active=1 or i_Tx_Done=1. No byte is ever lost or duplicated.
//  Byte counter width: $clog2(WORD_BYTES+2). Timeout counter: $clog2(TIMEOUT_CLKS+1). Both saturate-free and reset to 0.
//  i_Req may drop any time after o_Ack; i_Data is sampled only in the grant cycle.
//  i_Req held through a frame end is re-arbitrated in IDLE, so the requester does not get an implicit second grant.
//  Dropping i_Req before grant withdraws the request; there is no queueing.
//  Minimum gap between frames: one IDLE cycle.
//  Reset mid-frame: abort immediately, no o_Ack/o_Err. The next grant waits until the uart_tx handshake is idle.
// TESTING
//  (with uart_tx, CLKS_PER_BIT=4)
//  1 Single: i_Req=4'b0100, word 32'h11223344 -> o_Ack=4'b0100 once.
//    Serial line carries A2,11,22,33,44, 10 bits each. o_Busy falls after the 5th i_Tx_Done.
//  2 Round-robin: i_Req=4'b1111 held -> grant order 0,1,2,3,0. Headers A0,A1,A2,A3,A0.
//  3 Pacing: DV count equals i_Tx_Done rising-edge count (5 per frame).
//    No DV while i_Tx_Active=1 or i_Tx_Done=1.
//  4 Timeout: stub i_Tx_Done=0 forever -> o_Err pulse TIMEOUT_CLKS cycles after the first DV, then back to IDLE.
//  5 Reset mid-byte: i_Reset for 1 cycle during data byte 2 -> outputs 0.
//    Next grant occurs only after uart_tx finishes the byte and i_Tx_Done falls.
//  6 Data hold: change i_Data[req 1] one cycle after o_Ack[1] -> transmitted bytes match the value at the grant cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx byte transmitter between NUM_REQ word
// producers. Each granted word goes out as one frame: a header byte
// (HDR_BASE | winner index), then WORD_BYTES data bytes, MSB byte first.
// Bytes are paced from the transmitter's o_Tx_Active / o_Tx_Done handshake.
module uart_tx_arbiter #(
    parameter int         NUM_REQ      = 4,
    parameter int         WORD_BYTES   = 4,
    parameter logic [7:0] HDR_BASE     = 8'hA0,
    parameter int         TIMEOUT_CLKS = 4096
) (
    input  logic                            i_Clock,
    input  logic                            i_Reset,
    input  logic [NUM_REQ-1:0]              i_Req,
    input  logic [NUM_REQ*WORD_BYTES*8-1:0] i_Data,
    output logic [NUM_REQ-1:0]              o_Ack,
    output logic                            o_Busy,
    output logic                            o_Err,
    output logic                            o_Tx_DV,
    output logic [7:0]                      o_Tx_Byte,
    input  logic                            i_Tx_Active,
    input  logic                            i_Tx_Done
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WORD_W = WORD_BYTES * 8;
    localparam int CNT_W  = $clog2(WORD_BYTES + 2);
    localparam int TMO_W  = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        GAP
    } state_t;

    state_t               state_reg;
    logic [WORD_W-1:0]    shift_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [IDX_W-1:0]     last_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [TMO_W-1:0]     tmo_reg;
    logic [NUM_REQ-1:0]   ack_reg;
    logic                 busy_reg;
    logic                 err_reg;
    logic                 dv_reg;
    logic [7:0]           tx_byte_reg;

    logic [WORD_W-1:0]    words [NUM_REQ];
    logic                 win_found_next;
    logic [IDX_W-1:0]     win_idx_next;
    logic [IDX_W:0]       cand;

    // Unpack the flat input bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
            assign words[gi] = i_Data[gi*WORD_W +: WORD_W];
        end
    endgenerate

    // Round-robin search: scan from last_reg+1 upward; iterating from the far
    // end down lets the nearest requester overwrite any farther one.
    always_comb begin
        win_found_next = 1'b0;
        win_idx_next   = '0;
        cand           = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last_reg} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (i_Req[cand[IDX_W-1:0]]) begin
                win_found_next = 1'b1;
                win_idx_next   = cand[IDX_W-1:0];
            end
        end
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            idx_reg     <= '0;
            last_reg    <= IDX_W'(NUM_REQ - 1);
            cnt_reg     <= '0;
            tmo_reg     <= '0;
            ack_reg     <= '0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
            dv_reg      <= 1'b0;
            tx_byte_reg <= '0;
        end else begin
            ack_reg <= '0;
            dv_reg  <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    // Both handshake lines low means the transmitter is truly
                    // idle, even if a reset left it in the middle of a byte.
                    if (win_found_next && !i_Tx_Active && !i_Tx_Done) begin
                        shift_reg <= words[win_idx_next];
                        idx_reg   <= win_idx_next;
                        last_reg  <= win_idx_next;
                        ack_reg   <= NUM_REQ'(1) << win_idx_next;
                        cnt_reg   <= '0;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    busy_reg    <= 1'b1;
                    dv_reg      <= 1'b1;
                    tx_byte_reg <= (cnt_reg == '0) ? (HDR_BASE | 8'(idx_reg))
                                                   : shift_reg[WORD_W-1 -: 8];
                    // Loaded with 1 so the abort lands exactly TIMEOUT_CLKS
                    // cycles after the DV pulse is presented.
                    tmo_reg     <= TMO_W'(1);
                    state_reg   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        state_reg <= GAP;
                    end else if (tmo_reg == TMO_W'(TIMEOUT_CLKS)) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                GAP: begin
                    // Done low again means the transmitter is back in its idle
                    // state and will sample the next DV.
                    if (!i_Tx_Done) begin
                        // The header does not consume a data byte, so the
                        // word only advances after a data byte has gone out.
                        if (cnt_reg != '0) begin
                            shift_reg <= shift_reg << 8;
                        end
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(WORD_BYTES)) begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= SEND;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_Ack     = ack_reg;
    assign o_Busy    = busy_reg;
    assign o_Err     = err_reg;
    assign o_Tx_DV   = dv_reg;
    assign o_Tx_Byte = tx_byte_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural uart_tx (CLKS_PER_BIT=4) drives the
// serial line, a line receiver decodes the bytes, and a scoreboard holds the
// expected bytes and acks pushed when each request is driven.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int WB  = 4;
    localparam int TMO = 100;
    localparam int CPB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*WB*8-1:0] data;
    logic [NR-1:0]     ack;
    logic              busy, err, dv;
    logic [7:0]        tx_byte;
    logic              tx_active, tx_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .WORD_BYTES(WB), .HDR_BASE(8'hA0), .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req), .i_Data(data),
        .o_Ack(ack), .o_Busy(busy), .o_Err(err), .o_Tx_DV(dv),
        .o_Tx_Byte(tx_byte), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural uart_tx ----------------
    logic       stub     = 1'b0;
    logic       m_active = 1'b0;
    logic       m_done   = 1'b0;
    logic       serial   = 1'b1;
    logic [2:0] m_st     = 3'd0;
    int         m_cnt    = 0;
    int         m_bit    = 0;
    logic [7:0] m_byte   = 8'h00;

    assign tx_active = stub ? 1'b0 : m_active;
    assign tx_done   = stub ? 1'b0 : m_done;

    always @(posedge clk) begin
        case (m_st)
            3'd0: begin
                serial <= 1'b1;
                m_done <= 1'b0;
                m_cnt  <= 0;
                m_bit  <= 0;
                if (dv && !stub) begin
                    m_active <= 1'b1;
                    m_byte   <= tx_byte;
                    m_st     <= 3'd1;
                end
            end
            3'd1: begin
                serial <= 1'b0;
                if (m_cnt < CPB-1) m_cnt <= m_cnt + 1;
                else begin m_cnt <= 0; m_st <= 3'd2; end
            end
            3'd2: begin
                serial <= m_byte[m_bit];
                if (m_cnt < CPB-1) m_cnt <= m_cnt + 1;
                else begin
                    m_cnt <= 0;
                    if (m_bit < 7) m_bit <= m_bit + 1;
                    else begin m_bit <= 0; m_st <= 3'd3; end
                end
            end
            3'd3: begin
                serial <= 1'b1;
                if (m_cnt < CPB-1) m_cnt <= m_cnt + 1;
                else begin
                    m_cnt    <= 0;
                    m_done   <= 1'b1;
                    m_active <= 1'b0;
                    m_st     <= 3'd4;
                end
            end
            default: begin
                m_done <= 1'b1;
                m_st   <= 3'd0;
            end
        endcase
    end

    // ---------------- scoreboard and monitors ----------------
    logic [7:0]    exp_bytes[$];
    logic [NR-1:0] exp_acks[$];
    int cyc = 0, ack_seen = 0, dv_cnt = 0, done_rise = 0, err_cnt = 0;
    int dv_cyc = 0, err_cyc = 0;
    logic done_q = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (ack != '0) begin
            ack_seen++;
            $display("ack %b at cycle %0d", ack, cyc);
            if (exp_acks.size() == 0) check("ack_unexpected", 64'(ack), 64'd0);
            else check("ack", 64'(ack), 64'(exp_acks.pop_front()));
        end
        if (dv) begin
            dv_cnt++;
            dv_cyc = cyc;
            check("dv_when_idle", 64'({tx_active, tx_done}), 64'd0);
        end
        if (tx_done && !done_q) done_rise++;
        done_q = tx_done;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
            $display("err pulse at cycle %0d", cyc);
        end
    end

    // Serial line receiver: samples mid-bit on a falling start edge.
    initial forever begin
        logic [7:0] b;
        @(negedge serial);
        repeat (CPB/2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            b[i] = serial;
        end
        repeat (CPB) @(posedge clk);
        check("rx_stop", 64'(serial), 64'd1);
        $display("rx byte %02h", b);
        if (exp_bytes.size() == 0) check("rx_unexpected", 64'(b), 64'h100);
        else check("rx_byte", 64'(b), 64'(exp_bytes.pop_front()));
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_word(input int k, input logic [31:0] w);
        data[k*32 +: 32] = w;
    endtask

    task automatic push_frame(input int k, input logic [31:0] w);
        logic [7:0] hdr;
        hdr = 8'hA0 | 8'(k);
        exp_bytes.push_back(hdr);
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(w[i*8 +: 8]);
    endtask

    task automatic wait_acks(input int n);
        for (int i = 0; i < 3000 && ack_seen < n; i++) tick();
        check("ack_wait", 64'(ack_seen >= n), 64'd1);
    endtask

    task automatic wait_frame_end();
        for (int i = 0; i < 3000 && !busy; i++) tick();
        for (int i = 0; i < 3000 && busy; i++) tick();
        check("frame_end_wait", 64'(busy), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_dv, base_done, base_r;
        rst = 1'b1;
        req = '0;
        data = '0;
        set_word(0, 32'hDEADBEEF);
        set_word(1, 32'h01234567);
        set_word(2, 32'h11223344);
        set_word(3, 32'hCAFEF00D);
        repeat (3) tick();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_dv", 64'(dv), 64'd0);
        check("rst_byte", 64'(tx_byte), 64'd0);
        rst = 1'b0;
        tick();

        // Round-robin from reset: 0,1,2,3,0 with all requests held.
        exp_acks.push_back(4'b0001); push_frame(0, 32'hDEADBEEF);
        exp_acks.push_back(4'b0010); push_frame(1, 32'h01234567);
        exp_acks.push_back(4'b0100); push_frame(2, 32'h11223344);
        exp_acks.push_back(4'b1000); push_frame(3, 32'hCAFEF00D);
        exp_acks.push_back(4'b0001); push_frame(0, 32'hDEADBEEF);
        req = 4'b1111;
        wait_acks(5);
        req = '0;
        wait_frame_end();
        check("rr_dv_count", 64'(dv_cnt), 64'd25);
        check("rr_done_count", 64'(done_rise), 64'd25);

        // Single request from requester 2.
        base_dv = dv_cnt;
        base_done = done_rise;
        exp_acks.push_back(4'b0100); push_frame(2, 32'h11223344);
        req = 4'b0100;
        wait_acks(6);
        check("busy_at_ack", 64'(busy), 64'd0);
        req = '0;
        tick();
        check("busy_after_ack", 64'(busy), 64'd1);
        wait_frame_end();
        check("single_done_count", 64'(done_rise - base_done), 64'd5);
        check("single_dv_count", 64'(dv_cnt - base_dv), 64'd5);

        // Data hold: word changes the cycle after the ack.
        exp_acks.push_back(4'b0010); push_frame(1, 32'h01234567);
        req = 4'b0010;
        wait_acks(7);
        tick();
        set_word(1, 32'hFFFFFFFF);
        req = '0;
        wait_frame_end();

        // Timeout: transmitter stubbed so Done never comes.
        stub = 1'b1;
        exp_acks.push_back(4'b0001);
        req = 4'b0001;
        wait_acks(8);
        req = '0;
        for (int i = 0; i < 1000 && err_cnt == 0; i++) tick();
        check("err_wait", 64'(err_cnt), 64'd1);
        check("timeout_cycles", 64'(err_cyc - dv_cyc), 64'(TMO));
        check("busy_after_abort", 64'(busy), 64'd0);
        tick();
        check("err_one_cycle", 64'(err), 64'd0);
        stub = 1'b0;

        // Recovery after abort: requester 3 is next in rotation.
        exp_acks.push_back(4'b1000); push_frame(3, 32'hCAFEF00D);
        req = 4'b1000;
        wait_acks(9);
        req = '0;
        wait_frame_end();

        // Reset during data byte 2; the in-flight byte still completes.
        base_dv = dv_cnt;
        exp_acks.push_back(4'b0100);
        exp_bytes.push_back(8'hA2);
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        req = 4'b0100;
        wait_acks(10);
        req = '0;
        for (int i = 0; i < 3000 && dv_cnt < base_dv + 3; i++) tick();
        check("third_dv_wait", 64'(dv_cnt - base_dv), 64'd3);
        repeat (6) tick();
        check("mid_byte_active", 64'(tx_active), 64'd1);
        rst = 1'b1;
        req = 4'b0001;
        exp_acks.push_back(4'b0001); push_frame(0, 32'hDEADBEEF);
        base_r = done_rise;
        tick();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_dv", 64'(dv), 64'd0);
        check("midrst_ack", 64'(ack), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        rst = 1'b0;
        wait_acks(11);
        check("grant_after_done", 64'(done_rise - base_r), 64'd1);
        check("grant_tx_idle", 64'({tx_active, tx_done}), 64'd0);
        req = '0;
        wait_frame_end();

        repeat (50) tick();
        check("bytes_left", 64'(exp_bytes.size()), 64'd0);
        check("acks_left", 64'(exp_acks.size()), 64'd0);
        check("err_total", 64'(err_cnt), 64'd1);
        check("dv_vs_done", 64'(dv_cnt), 64'(done_rise + 1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
